// File: rtl/msoc_cpu_debug_host_shifter.sv
// Host-side initiator for the Nios II debug virtual-JTAG channel: takes one
// command, walks update-IR / capture-DR / shift-DR / update-DR / run-test-idle.
module msoc_cpu_debug_host_shifter #(
  parameter int SR_WIDTH    = 38,
  parameter int IR_WIDTH    = 2,
  parameter int IDLE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [SR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [SR_WIDTH-1:0] rsp_data,
  output logic [IR_WIDTH-1:0] rsp_status,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  input  logic [IR_WIDTH-1:0] vji_ir_out
);

  localparam int CNT_W    = $clog2(SR_WIDTH);
  localparam int RTI_W    = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
  localparam int RTI_LAST = (IDLE_CYCLES > 0) ? IDLE_CYCLES - 1 : 0;

  typedef enum logic [2:0] {
    S_IDLE, S_UIR, S_CDR, S_SDR, S_UDR, S_RTI, S_RSP
  } state_t;

  state_t              state, state_nxt;
  logic [SR_WIDTH-1:0] shreg;
  logic [CNT_W-1:0]    bit_cnt;
  logic [RTI_W-1:0]    rti_cnt;
  logic                ir_loaded;
  logic                need_uir;
  logic                shift_done;
  logic                rti_done;

  // UIR is skipped only when the slave already holds the requested IR
  assign need_uir   = !ir_loaded || (cmd_ir != vji_ir_in);
  assign shift_done = (bit_cnt == CNT_W'(SR_WIDTH - 1));
  assign rti_done   = (rti_cnt == RTI_W'(RTI_LAST));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (cmd_valid) state_nxt = need_uir ? S_UIR : S_CDR;
      S_UIR:   state_nxt = S_CDR;
      S_CDR:   state_nxt = S_SDR;
      S_SDR:   if (shift_done) state_nxt = S_UDR;
      S_UDR:   state_nxt = (IDLE_CYCLES == 0) ? S_RSP : S_RTI;
      S_RTI:   if (rti_done) state_nxt = S_RSP;
      S_RSP:   if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      rti_cnt    <= '0;
      ir_loaded  <= 1'b0;
      vji_ir_in  <= '0;
      rsp_status <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            shreg <= cmd_data;
            if (need_uir) begin
              vji_ir_in <= cmd_ir;
              ir_loaded <= 1'b1;
            end
          end
        end
        S_CDR: begin
          rsp_status <= vji_ir_out;
          bit_cnt    <= '0;
        end
        // LSB leaves on tdi while tdo enters at the top, so after the last
        // shift the register holds the slave's word in natural bit order
        S_SDR: begin
          shreg   <= {vji_tdo, shreg[SR_WIDTH-1:1]};
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
        S_UDR:   rti_cnt <= '0;
        S_RTI:   rti_cnt <= rti_cnt + RTI_W'(1);
        default: ;
      endcase
    end
  end

  assign cmd_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RSP);
  assign rsp_data  = shreg;
  assign vji_uir   = (state == S_UIR);
  assign vji_cdr   = (state == S_CDR);
  assign vji_sdr   = (state == S_SDR);
  assign vji_udr   = (state == S_UDR);
  assign vji_rti   = (state == S_IDLE) || (state == S_RTI);
  assign vji_tdi   = (state == S_SDR) && shreg[0];

endmodule
